// File: rtl/conv_window_mac.sv
// Sequential valid-region 2-D convolution: one MAC per enabled cycle over a
// pre-rotated SIZE x SIZE kernel, saturating each result into a registered OUT x OUT array.
module conv_window_mac #(
   parameter int unsigned SIZE = 3,
   parameter int unsigned IMG  = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        start,
   input  logic [31:0] KernelArray [SIZE][SIZE],
   input  logic [31:0] ImageArray  [IMG][IMG],
   output logic [31:0] ConvArray   [IMG-SIZE+1][IMG-SIZE+1],
   output logic        busy,
   output logic        done
);

   localparam int unsigned OUT = IMG - SIZE + 1;
   localparam int unsigned KW  = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int unsigned OW  = (OUT > 1)  ? $clog2(OUT)  : 1;
   localparam int unsigned IW  = (IMG > 1)  ? $clog2(IMG)  : 1;
   localparam int unsigned AW  = 72;

   localparam logic signed [AW-1:0] SAT_MAX = 72'sh7FFF_FFFF;
   localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - 72'sd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_STORE,
      S_DONE
   } state_e;

   state_e                 state_q;
   logic [31:0]            ker_q [SIZE][SIZE];
   logic [31:0]            img_q [IMG][IMG];
   logic signed [AW-1:0]   acc_q;
   logic [OW-1:0]          orow_q, ocol_q;
   logic [KW-1:0]          kr_q, kc_q;

   logic [IW-1:0]          row_idx_c, col_idx_c;
   logic signed [31:0]     pix_c, tap_c;
   logic signed [63:0]     prod_c;
   logic signed [AW-1:0]   acc_d;
   logic [31:0]            sat_c;

   // Current tap product, next accumulator value and clamped result.
   always_comb begin
      row_idx_c = IW'(orow_q) + IW'(kr_q);
      col_idx_c = IW'(ocol_q) + IW'(kc_q);
      pix_c     = img_q[row_idx_c][col_idx_c];
      tap_c     = ker_q[kr_q][kc_q];
      prod_c    = 64'(pix_c) * 64'(tap_c);
      acc_d     = acc_q + AW'(prod_c);
      if (acc_q > SAT_MAX) begin
         sat_c = 32'h7FFF_FFFF;
      end else if (acc_q < SAT_MIN) begin
         sat_c = 32'h8000_0000;
      end else begin
         sat_c = acc_q[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ker_q     <= '{default: '0};
         img_q     <= '{default: '0};
         ConvArray <= '{default: '0};
         acc_q     <= '0;
         orow_q    <= '0;
         ocol_q    <= '0;
         kr_q      <= '0;
         kc_q      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (en) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ker_q   <= KernelArray;
                  img_q   <= ImageArray;
                  acc_q   <= '0;
                  orow_q  <= '0;
                  ocol_q  <= '0;
                  kr_q    <= '0;
                  kc_q    <= '0;
                  busy    <= 1'b1;
                  state_q <= S_MAC;
               end
            end
            S_MAC: begin
               acc_q <= acc_d;
               if (kc_q == KW'(SIZE - 1)) begin
                  kc_q <= '0;
                  if (kr_q == KW'(SIZE - 1)) begin
                     state_q <= S_STORE;
                  end else begin
                     kr_q <= kr_q + KW'(1);
                  end
               end else begin
                  kc_q <= kc_q + KW'(1);
               end
            end
            S_STORE: begin
               ConvArray[orow_q][ocol_q] <= sat_c;
               acc_q <= '0;
               kr_q  <= '0;
               kc_q  <= '0;
               if (ocol_q == OW'(OUT - 1)) begin
                  ocol_q <= '0;
                  if (orow_q == OW'(OUT - 1)) begin
                     orow_q  <= '0;
                     done    <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     orow_q  <= orow_q + OW'(1);
                     state_q <= S_MAC;
                  end
               end else begin
                  ocol_q  <= ocol_q + OW'(1);
                  state_q <= S_MAC;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: latency, values, saturation, stall,
// ignored start and mid-run reset with hand-computed expectations.
module tb_conv_window_mac;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        start;
   logic [31:0] ker  [3][3];
   logic [31:0] img  [5][5];
   logic [31:0] conv [3][3];
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   conv_window_mac #(.SIZE(3), .IMG(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .start       (start),
      .KernelArray (ker),
      .ImageArray  (img),
      .ConvArray   (conv),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         tick(1);
         n++;
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] exp);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            chk($sformatf("%s[%0d][%0d]", tag, r, c), conv[r][c], exp);
   endtask

   task automatic chk_identity(input string tag);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            chk($sformatf("%s[%0d][%0d]", tag, r, c), conv[r][c],
                32'(10 * (r + 1) + (c + 1)));
   endtask

   task automatic set_ramp_kernel_ones_image();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            ker[r][c] = 32'(4 - r - c);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            img[r][c] = 32'd1;
   endtask

   task automatic set_identity();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            ker[r][c] = (r == 1 && c == 1) ? 32'd1 : 32'd0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            img[r][c] = 32'(10 * r + c);
   endtask

   task automatic set_uniform(input logic [31:0] k, input logic [31:0] p);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            ker[r][c] = k;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            img[r][c] = p;
   endtask

   initial begin
      int n;
      int e;
      int extra;

      reset = 1'b1;
      en    = 1'b1;
      start = 1'b0;
      set_ramp_kernel_ones_image();
      tick(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk_all("rst_conv", 32'd0);
      reset = 1'b0;
      tick(1);

      // Ramp kernel over an all-ones image: every window sums to 18.
      do_start();
      chk("s1_busy_e0", 32'(busy), 32'd1);
      chk("s1_done_e0", 32'(done), 32'd0);
      tick(9);
      chk("s1_c00_e9", conv[0][0], 32'd0);
      tick(1);
      chk("s1_c00_e10", conv[0][0], 32'd18);
      tick(79);
      chk("s1_done_e89", 32'(done), 32'd0);
      chk("s1_busy_e89", 32'(busy), 32'd1);
      tick(1);
      chk("s1_done_e90", 32'(done), 32'd1);
      chk("s1_busy_e90", 32'(busy), 32'd1);
      tick(1);
      chk("s1_done_e91", 32'(done), 32'd0);
      chk("s1_busy_e91", 32'(busy), 32'd0);
      chk_all("s1_conv", 32'd18);

      set_identity();
      do_start();
      wait_done(n);
      chk("id_latency", 32'(n), 32'd90);
      chk("id_c00", conv[0][0], 32'd11);
      chk("id_c22", conv[2][2], 32'd33);
      chk_identity("id_conv");
      tick(1);

      set_uniform(32'd2, 32'h7FFF_FFFF);
      do_start();
      wait_done(n);
      chk("satp_latency", 32'(n), 32'd90);
      chk_all("satp_conv", 32'h7FFF_FFFF);
      tick(1);

      set_uniform(32'd2, 32'h8000_0000);
      do_start();
      wait_done(n);
      chk_all("satn_conv", 32'h8000_0000);
      tick(1);

      set_uniform(32'd1, 32'hFFFF_FFFF);
      do_start();
      wait_done(n);
      chk_all("neg_conv", 32'hFFFF_FFF7);
      tick(1);

      // Ten-cycle stall plus a start pulse while busy.
      set_ramp_kernel_ones_image();
      do_start();
      tick(40);
      en = 1'b0;
      tick(10);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_done", 32'(done), 32'd0);
      en = 1'b1;
      tick(9);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      e = 60;
      while (done !== 1'b1 && e < 300) begin
         tick(1);
         e++;
      end
      chk("stall_done_edge", 32'(e), 32'd100);
      extra = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (done === 1'b1) extra++;
      end
      chk("stall_extra_done", 32'(extra), 32'd0);
      chk("stall_busy_after", 32'(busy), 32'd0);
      chk_all("stall_conv", 32'd18);

      // Reset mid-run aborts and clears outputs without a done pulse.
      set_identity();
      do_start();
      tick(44);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk_all("mrst_conv", 32'd0);
      extra = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      chk("mrst_no_activity", 32'(extra), 32'd0);
      do_start();
      wait_done(n);
      chk("mrst_rerun_latency", 32'(n), 32'd90);
      chk_identity("mrst_rerun_conv");
      tick(1);

      // Reset and start together: reset wins.
      reset = 1'b1;
      start = 1'b1;
      tick(1);
      reset = 1'b0;
      start = 1'b0;
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_conv00", conv[0][0], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
